// File: rtl/ram512_pkg.sv
// Shared sizing constants and address-split helpers for the 512x16 RAM.
// The RAM is organised as eight 64-word banks selected by the top address bits.
package ram512_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 9;
    localparam int WORDS      = 512;
    localparam int BANKS      = 8;
    localparam int BANK_WORDS = 64;
    localparam int BANK_AW    = 6;
    localparam int BANK_SEL_W = 3;

    function automatic logic [BANK_SEL_W-1:0] bankSelect(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:BANK_AW];
    endfunction

    function automatic logic [BANK_AW-1:0] bankOffset(input logic [ADDR_W-1:0] addr);
        return addr[BANK_AW-1:0];
    endfunction

endpackage

// File: rtl/ram512_if.sv
// Bus bundle for the 512x16 RAM: write data, write enable, address and read data.
// The RAM sits on the slave side; whoever drives writes and reads is the master.
interface ram512_if;
    import ram512_pkg::*;

    logic [DATA_W-1:0] value;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] out;

    modport master (
        output value,
        output load,
        output address,
        input  out
    );

    modport slave (
        input  value,
        input  load,
        input  address,
        output out
    );

endinterface

// File: rtl/ram512_ram64.sv
// 64x16 register-file bank: synchronous write, combinational read,
// and an asynchronous reset that clears every word at once.
module ram64
    import ram512_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  value,
    input  logic               load,
    input  logic [BANK_AW-1:0] address,
    output logic [DATA_W-1:0]  out
);

    logic [DATA_W-1:0] r_mem [BANK_WORDS];

    // Reset clears the whole bank and also blocks any write presented alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BANK_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (load) begin
            r_mem[address] <= value;
        end
    end

    assign out = r_mem[address];

endmodule

// File: rtl/ram512.sv
// 512x16 RAM built from eight 64-word banks; address[8:6] picks the bank,
// address[5:0] the word inside it.
module ram512
    import ram512_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    ram512_if.slave bus
);

    logic [BANK_SEL_W-1:0] w_bankSel;
    logic [BANK_AW-1:0]    w_offset;
    logic [BANKS-1:0]      w_bankLoad;
    logic [DATA_W-1:0]     w_bankOut [BANKS];

    assign w_bankSel = bankSelect(bus.address);
    assign w_offset  = bankOffset(bus.address);

    // Only the addressed bank sees the write enable, so other banks hold their words.
    always_comb begin
        w_bankLoad            = '0;
        w_bankLoad[w_bankSel] = bus.load;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram64 u_bank (
            .clk     (clk),
            .reset   (reset),
            .value   (bus.value),
            .load    (w_bankLoad[b]),
            .address (w_offset),
            .out     (w_bankOut[b])
        );
    end

    assign bus.out = w_bankOut[w_bankSel];

endmodule

// File: tb/tb_ram512.sv
// Directed self-checking bench for ram512: reset clearing, writes, bank
// boundaries, hold behaviour and reset priority over writes.
module tb_ram512;
    import ram512_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    ram512_if bus ();

    ram512 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] val,
                                 input logic ld);
        bus.address = addr;
        bus.value   = val;
        bus.load    = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] addrs [3];
        addrs = '{9'd0, 9'd131, 9'd511};
        applyStimulus(9'd0, 16'h0000, 1'b0);
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        foreach (addrs[i]) begin
            bus.address = addrs[i];
            #1;
            checks++;
            if (bus.out !== 16'h0000) begin
                failures++;
                $display("[TB] FAIL reset_read addr=%0d got=%h exp=0000", addrs[i], bus.out);
            end
        end
    endtask

    task automatic test_write_read();
        applyStimulus(9'd131, 16'h0003, 1'b1);
        tick();
        applyStimulus(9'd109, 16'h000F, 1'b1);
        tick();
        applyStimulus(9'd131, 16'h0000, 1'b0);
        #1;
        checks++;
        if (bus.out !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL write_read_131 got=%h exp=0003", bus.out);
        end
        bus.address = 9'd109;
        #1;
        checks++;
        if (bus.out !== 16'h000F) begin
            failures++;
            $display("[TB] FAIL write_read_109 got=%h exp=000f", bus.out);
        end
    endtask

    task automatic test_boundary();
        applyStimulus(9'd0, 16'hAAAA, 1'b1);
        tick();
        applyStimulus(9'd511, 16'h5555, 1'b1);
        tick();
        applyStimulus(9'd0, 16'h0000, 1'b0);
        #1;
        checks++;
        if (bus.out !== 16'hAAAA) begin
            failures++;
            $display("[TB] FAIL boundary_0 got=%h exp=aaaa", bus.out);
        end
        bus.address = 9'd511;
        #1;
        checks++;
        if (bus.out !== 16'h5555) begin
            failures++;
            $display("[TB] FAIL boundary_511 got=%h exp=5555", bus.out);
        end
        bus.address = 9'd64;
        #1;
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL alias_64 got=%h exp=0000", bus.out);
        end
        bus.address = 9'd447;
        #1;
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL alias_447 got=%h exp=0000", bus.out);
        end
    endtask

    task automatic test_hold();
        applyStimulus(9'd131, 16'hFFFF, 1'b0);
        repeat (3) tick();
        checks++;
        if (bus.out !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL hold_131 got=%h exp=0003", bus.out);
        end
        // Glitch the write enable between edges; nothing may be stored.
        bus.address = 9'd200;
        bus.load    = 1'b1;
        #1 bus.load = 1'b0;
        bus.address = 9'd131;
        tick();
        checks++;
        if (bus.out !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL glitch_131 got=%h exp=0003", bus.out);
        end
        bus.address = 9'd200;
        #1;
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL glitch_200 got=%h exp=0000", bus.out);
        end
    endtask

    task automatic test_overwrite();
        applyStimulus(9'd200, 16'h1111, 1'b1);
        tick();
        checks++;
        if (bus.out !== 16'h1111) begin
            failures++;
            $display("[TB] FAIL same_cycle_read got=%h exp=1111", bus.out);
        end
        bus.value = 16'h2222;
        tick();
        bus.load = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h2222) begin
            failures++;
            $display("[TB] FAIL overwrite_200 got=%h exp=2222", bus.out);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W-1:0] vals  [4];
        addrs = '{9'd300, 9'd301, 9'd365, 9'd448};
        vals  = '{16'hC0DE, 16'hBEEF, 16'h7E57, 16'h0101};
        foreach (addrs[i]) begin
            applyStimulus(addrs[i], vals[i], 1'b1);
            tick();
        end
        bus.load = 1'b0;
        foreach (addrs[i]) begin
            bus.address = addrs[i];
            #1;
            checks++;
            if (bus.out !== vals[i]) begin
                failures++;
                $display("[TB] FAIL back_to_back addr=%0d got=%h exp=%h", addrs[i], bus.out, vals[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(9'd109, 16'h1234, 1'b1);
        tick();
        bus.load = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL pre_reset_109 got=%h exp=1234", bus.out);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL async_reset_109 got=%h exp=0000", bus.out);
        end
        applyStimulus(9'd511, 16'h9999, 1'b1);
        tick();
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL write_in_reset_511 got=%h exp=0000", bus.out);
        end
        bus.load = 1'b0;
        reset    = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL after_reset_511 got=%h exp=0000", bus.out);
        end
    endtask

    task automatic test_reset_vs_load();
        applyStimulus(9'd5, 16'hBEEF, 1'b1);
        reset = 1'b1;
        tick();
        bus.load = 1'b0;
        reset    = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_wins_5 got=%h exp=0000", bus.out);
        end
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        #1;
        checks++;
        if (bus.out !== 16'hBEEF) begin
            failures++;
            $display("[TB] FAIL first_write_after_reset got=%h exp=beef", bus.out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        applyStimulus(9'd0, 16'h0000, 1'b0);
        test_reset();
        test_write_read();
        test_boundary();
        test_hold();
        test_overwrite();
        test_back_to_back();
        test_async_reset();
        test_reset_vs_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram512.md
RAM512 -- requirements
Module: ram512

Interface
REQ-001: Parameters: none; data width fixed at 16 bits, depth fixed at 512 words, address width fixed at 9 bits.
REQ-002: clk  input  1  single clock; all writes occur on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset; clears all storage.
REQ-004: value  input  16  write data.
REQ-005: load  input  1  write enable; 1 = write value to address on the next rising clk edge.
REQ-006: address  input  9  word select, 0..511, used for both read and write.
REQ-007: out  output  16  contents of the word at address.

Function
REQ-008: Storage SHALL be 512 independent 16-bit words, indexed by address as an unsigned number (0..511).
REQ-009: Write: on rising clk with load=1 and reset=0, word[address] SHALL take value; all other words are unchanged.
REQ-010: With load=0, no word SHALL change on any clock edge.
REQ-011: Read SHALL be combinational: out = word[address] at all times, with zero-cycle latency from an address change.
REQ-012: Write-then-read: after a write edge, out SHALL show the newly written value in the same cycle when address is unchanged (no read-during-write bypass of the old value).
REQ-013: Back-to-back writes to different addresses on consecutive edges SHALL both persist; there is no handshake and no busy state.
REQ-014: Repeated writes to the same address SHALL keep only the last-written value.
REQ-015: Address 0 and address 511 SHALL behave identically to interior addresses; no wrap-around or aliasing is permitted.
REQ-016: Sampling of value, load and address SHALL occur only at the rising clk edge for writes; glitches between edges SHALL NOT alter storage.

Reset
REQ-017: Asserting reset SHALL immediately clear all 512 words to 16'h0000, without waiting for a clock edge.
REQ-018: While reset=1, writes SHALL be ignored and out SHALL read 16'h0000 for every address.
REQ-019: Reset asserted mid-operation, including in the same cycle as load=1, SHALL win: that word ends at zero.
REQ-020: After reset is deasserted, the first rising edge with load=1 SHALL write normally.

Structure
REQ-021: No shared package is required; if the team package exists, the constants DATA_W=16, ADDR_W=9 and WORDS=512 belong there.
REQ-022: The design SHALL be built from 8 instances of a sub-module ram64 (64x16, 6-bit address, same ports).
REQ-023: Decoding: address[8:6] selects the bank and address[5:0] is the bank-internal address.
REQ-024: load SHALL be gated to the selected bank only (1-of-8 demux).
REQ-025: out SHALL be an 8:1 mux of the bank outputs, selected by address[8:6].
REQ-026: ram64 SHALL itself implement per-word registers with asynchronous reset, combinational read and synchronous write.

Verification
REQ-027: Pulse reset, then read addresses 0, 131 and 511 with load=0 -> out = 0x0000 each.
REQ-028: load=1, address=131, value=0x0003, one edge; then address=109, value=0x000F, one edge; then load=0 and read 131 -> 0x0003, read 109 -> 0x000F.
REQ-029: Write 0xAAAA to address 0 and 0x5555 to address 511 -> both read back correctly, and address 64 (a different bank, same offset as 0) still reads 0x0000.
REQ-030: load=0, value=0xFFFF, toggle clk at address 131 -> out stays 0x0003.
REQ-031: Write 0x1234 to 109, then assert reset between clk edges -> out = 0x0000 immediately, before any further edge.
REQ-032: Reset and load=1 asserted together at address 5 -> after reset is released, address 5 reads 0x0000.
